// File: rtl/branch_ctrl.sv
// Next-PC and branch-resolution controller: owns the IF-stage PC and resolves
// branch/jump/jr in ID with one delay slot. It stalls ID/IF while branch operands are pending.
module branch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [7:0]  MAX_WAIT = 8'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic        id_branch,
  input  logic        id_jump,
  input  logic        id_jr,
  input  logic [31:0] id_pc,
  input  logic [15:0] id_imm16,
  input  logic [25:0] id_index26,
  input  logic [31:0] jr_target,
  input  logic        cmp_result,
  input  logic        opnd_ready,
  input  logic        hz_stall,
  output logic [31:0] pc_if,
  output logic        stall_id,
  output logic        redirect,
  output logic        pc_misalign,
  output logic        wait_timeout,
  output logic [31:0] taken_cnt,
  output logic [31:0] ntaken_cnt
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t      state_r, state_next_s;
  logic [31:0] pc_r, pc_next_s;
  logic        redirect_r, redirect_next_s;
  logic [31:0] taken_cnt_r, ntaken_cnt_r;
  logic [7:0]  wait_cnt_r, wait_cnt_next_s;
  logic        wait_timeout_r;
  logic        is_jr_s, is_j_s, is_br_s, ctl_s, needs_opnd_s;
  logic [31:0] pc4_id_s, br_target_s, j_target_s, target_s;
  logic        take_s, resolve_s, stall_s, taken_inc_s, ntaken_inc_s;

  // Type flags are decoded with jr > jump > branch priority in case several are set.
  assign is_jr_s      = id_jr;
  assign is_j_s       = id_jump & ~id_jr;
  assign is_br_s      = id_branch & ~id_jump & ~id_jr;
  assign ctl_s        = id_valid & (id_branch | id_jump | id_jr);
  assign needs_opnd_s = is_br_s | is_jr_s;
  assign pc4_id_s     = id_pc + 32'd4;
  assign br_target_s  = pc4_id_s + {{14{id_imm16[15]}}, id_imm16, 2'b00};
  assign j_target_s   = {pc4_id_s[31:28], id_index26, 2'b00};
  assign take_s       = ctl_s & (is_jr_s | is_j_s | (is_br_s & cmp_result));

  // Non-sequential target select.
  always_comb begin
    target_s = br_target_s;
    if (is_jr_s) begin
      target_s = jr_target;
    end else if (is_j_s) begin
      target_s = j_target_s;
    end else begin
      target_s = br_target_s;
    end
  end

  // FSM next state, resolve decision, next PC, counter increments and wait counter.
  always_comb begin
    state_next_s    = state_r;
    resolve_s       = 1'b0;
    stall_s         = 1'b0;
    pc_next_s       = pc_r;
    redirect_next_s = 1'b0;
    taken_inc_s     = 1'b0;
    ntaken_inc_s    = 1'b0;
    wait_cnt_next_s = 8'd0;
    case (state_r)
      ST_RUN: begin
        if (ctl_s & needs_opnd_s & ~opnd_ready) begin
          stall_s = 1'b1;
          if (~hz_stall) begin
            state_next_s = ST_WAIT;
          end else begin
            state_next_s = ST_RUN;
          end
        end else begin
          resolve_s = ~hz_stall;
        end
      end
      ST_WAIT: begin
        stall_s = 1'b1;
        if (opnd_ready & ~hz_stall) begin
          resolve_s    = 1'b1;
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      default: begin
        state_next_s = ST_RUN;
      end
    endcase

    if (resolve_s) begin
      redirect_next_s = take_s;
      if (take_s) begin
        pc_next_s = target_s;
      end else begin
        pc_next_s = pc_r + 32'd4;
      end
      taken_inc_s  = ctl_s & is_br_s & cmp_result;
      ntaken_inc_s = ctl_s & is_br_s & ~cmp_result;
    end else begin
      pc_next_s = pc_r;
    end

    // The wait counter only runs while the FSM stays in WAIT; it saturates rather than wraps.
    if ((state_r == ST_WAIT) && (state_next_s == ST_WAIT)) begin
      if (wait_cnt_r == 8'hFF) begin
        wait_cnt_next_s = wait_cnt_r;
      end else begin
        wait_cnt_next_s = wait_cnt_r + 8'd1;
      end
    end else begin
      wait_cnt_next_s = 8'd0;
    end
  end

  // State, PC, statistics and timeout registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_RUN;
      pc_r           <= RESET_PC;
      redirect_r     <= 1'b0;
      taken_cnt_r    <= 32'd0;
      ntaken_cnt_r   <= 32'd0;
      wait_cnt_r     <= 8'd0;
      wait_timeout_r <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      pc_r           <= pc_next_s;
      redirect_r     <= redirect_next_s;
      taken_cnt_r    <= taken_cnt_r + {31'd0, taken_inc_s};
      ntaken_cnt_r   <= ntaken_cnt_r + {31'd0, ntaken_inc_s};
      wait_cnt_r     <= wait_cnt_next_s;
      wait_timeout_r <= wait_timeout_r | (wait_cnt_next_s > MAX_WAIT);
    end
  end

  assign pc_if        = pc_r;
  assign redirect     = redirect_r;
  assign taken_cnt    = taken_cnt_r;
  assign ntaken_cnt   = ntaken_cnt_r;
  assign wait_timeout = wait_timeout_r;
  assign pc_misalign  = |pc_r[1:0];
  assign stall_id     = stall_s & ~reset;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed scenarios plus random traffic, all compared
// against a cycle-level reference model of the next-PC rules.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_branch, id_jump, id_jr;
  logic [31:0] id_pc;
  logic [15:0] id_imm16;
  logic [25:0] id_index26;
  logic [31:0] jr_target;
  logic        cmp_result, opnd_ready, hz_stall;
  logic [31:0] pc_if;
  logic        stall_id, redirect, pc_misalign, wait_timeout;
  logic [31:0] taken_cnt, ntaken_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_taken, m_ntaken;
  bit          m_wait, m_redir, m_to;
  int          m_wcnt;

  branch_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_branch(id_branch),
    .id_jump(id_jump), .id_jr(id_jr), .id_pc(id_pc), .id_imm16(id_imm16),
    .id_index26(id_index26), .jr_target(jr_target), .cmp_result(cmp_result),
    .opnd_ready(opnd_ready), .hz_stall(hz_stall), .pc_if(pc_if),
    .stall_id(stall_id), .redirect(redirect), .pc_misalign(pc_misalign),
    .wait_timeout(wait_timeout), .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input bit br, input bit j, input bit jr,
                       input logic [31:0] pc, input logic [15:0] imm, input logic [25:0] idx,
                       input logic [31:0] jrt, input bit cmp, input bit rdy, input bit hz);
    id_valid = v; id_branch = br; id_jump = j; id_jr = jr;
    id_pc = pc; id_imm16 = imm; id_index26 = idx; jr_target = jrt;
    cmp_result = cmp; opnd_ready = rdy; hz_stall = hz;
  endtask

  task automatic m_reset();
    m_pc = 32'h0000_3000; m_taken = 32'd0; m_ntaken = 32'd0;
    m_wait = 1'b0; m_redir = 1'b0; m_to = 1'b0; m_wcnt = 0;
  endtask

  function automatic bit exp_stall();
    bit ctl, needs;
    ctl   = id_valid && (id_branch || id_jump || id_jr);
    needs = id_jr || (id_branch && !id_jump);
    if (reset) return 1'b0;
    return m_wait || (ctl && needs && !opnd_ready);
  endfunction

  // One clock edge of the architectural rules.
  task automatic model_edge();
    bit ctl, jr, jp, br, needs, go, was;
    int off;
    logic [31:0] tgt;
    ctl   = id_valid && (id_branch || id_jump || id_jr);
    jr    = id_jr;
    jp    = id_jump && !id_jr;
    br    = id_branch && !jp && !jr;
    needs = jr || br;
    was   = m_wait;
    m_redir = 1'b0;
    if (hz_stall) go = 1'b0;
    else if (m_wait) go = opnd_ready;
    else go = !(ctl && needs && !opnd_ready);
    if (!m_wait && !hz_stall && ctl && needs && !opnd_ready) m_wait = 1'b1;
    if (go) begin
      m_wait = 1'b0;
      if (ctl && (jr || jp || (br && cmp_result))) begin
        off = $signed(id_imm16);
        if (jr) tgt = jr_target;
        else if (jp) tgt = ((id_pc + 32'd4) & 32'hF000_0000) | (32'(id_index26) << 2);
        else tgt = id_pc + 32'd4 + 32'(off * 4);
        m_pc = tgt;
        m_redir = 1'b1;
      end else begin
        m_pc = m_pc + 32'd4;
      end
      if (ctl && br) begin
        if (cmp_result) m_taken = m_taken + 32'd1;
        else m_ntaken = m_ntaken + 32'd1;
      end
    end
    if (was && m_wait) m_wcnt = (m_wcnt < 255) ? m_wcnt + 1 : 255;
    else m_wcnt = 0;
    if (m_wcnt > 8) m_to = 1'b1;
  endtask

  task automatic step();
    #1;
    check("stall_id", {31'd0, stall_id}, {31'd0, exp_stall()});
    @(posedge clk);
    model_edge();
    #1;
    check("pc_if", pc_if, m_pc);
    check("redirect", {31'd0, redirect}, {31'd0, m_redir});
    check("taken_cnt", taken_cnt, m_taken);
    check("ntaken_cnt", ntaken_cnt, m_ntaken);
    check("wait_timeout", {31'd0, wait_timeout}, {31'd0, m_to});
    check("pc_misalign", {31'd0, pc_misalign}, {31'd0, (m_pc[1:0] != 2'b00)});
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 32'd0, 16'd0, 26'd0, 32'd0, 0, 1, 0);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc_if, 32'h0000_3000);
    check("rst_stall", {31'd0, stall_id}, 32'd0);
    check("rst_redirect", {31'd0, redirect}, 32'd0);
    check("rst_taken", taken_cnt, 32'd0);
    check("rst_ntaken", ntaken_cnt, 32'd0);
    check("rst_timeout", {31'd0, wait_timeout}, 32'd0);
    check("rst_misalign", {31'd0, pc_misalign}, 32'd0);
    reset = 1'b0;

    for (int i = 1; i <= 4; i++) begin
      step();
      check("seq_pc", pc_if, 32'h0000_3000 + 32'(4 * i));
    end

    // beq taken then not taken
    drive(1, 1, 0, 0, 32'h3008, 16'hFFFE, 26'd0, 32'd0, 1, 1, 0);
    step();
    check("beq_t_pc", pc_if, 32'h0000_3004);
    check("beq_t_redir", {31'd0, redirect}, 32'd1);
    check("beq_t_cnt", taken_cnt, 32'd1);
    drive(1, 1, 0, 0, 32'h3008, 16'hFFFE, 26'd0, 32'd0, 0, 1, 0);
    step();
    check("beq_nt_cnt", ntaken_cnt, 32'd1);
    check("beq_nt_pc", pc_if, 32'h0000_3008);

    // bne waiting 3 cycles on operands
    drive(1, 1, 0, 0, 32'h3010, 16'h0004, 26'd0, 32'd0, 1, 0, 0);
    repeat (3) begin
      step();
      check("wait_hold_pc", pc_if, 32'h0000_3008);
    end
    opnd_ready = 1'b1;
    step();
    check("bne_pc", pc_if, 32'h0000_3024);
    check("bne_redir", {31'd0, redirect}, 32'd1);
    check("bne_to", {31'd0, wait_timeout}, 32'd0);

    // j never waits, even with operands pending
    drive(1, 0, 1, 0, 32'h3FFF_FFFC, 16'd0, 26'h000_0010, 32'd0, 0, 0, 0);
    step();
    check("j_pc", pc_if, 32'h4000_0040);
    drive(1, 0, 0, 1, 32'h4000_0040, 16'd0, 26'd0, 32'h0000_3002, 0, 1, 0);
    step();
    check("jr_pc", pc_if, 32'h0000_3002);
    check("jr_misalign", {31'd0, pc_misalign}, 32'd1);

    // hz_stall over a ready branch, decision flips before release
    drive(1, 1, 0, 0, 32'h3100, 16'h0010, 26'd0, 32'd0, 0, 1, 1);
    step();
    step();
    cmp_result = 1'b1;
    step();
    check("hz_hold_pc", pc_if, 32'h0000_3002);
    hz_stall = 1'b0;
    step();
    check("hz_pc", pc_if, 32'h0000_3144);
    check("hz_taken", taken_cnt, 32'd3);

    // Random traffic
    repeat (300) begin
      drive(($urandom % 4) != 0, $urandom % 2, ($urandom % 3) == 0, ($urandom % 4) == 0,
            $urandom, 16'($urandom), 26'($urandom), $urandom,
            $urandom % 2, ($urandom % 4) != 0, ($urandom % 5) == 0);
      step();
    end

    reset = 1'b1;
    #1;
    check("rst2_pc", pc_if, 32'h0000_3000);
    m_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Operand wait of 10 cycles raises the sticky timeout
    drive(1, 1, 0, 0, 32'h3000, 16'h0008, 26'd0, 32'd0, 1, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 9) check("to_before", {31'd0, wait_timeout}, 32'd0);
    end
    check("to_set", {31'd0, wait_timeout}, 32'd1);
    step();
    step();
    check("to_sticky", {31'd0, wait_timeout}, 32'd1);

    // Reset mid-WAIT
    reset = 1'b1;
    #1;
    check("rstw_pc", pc_if, 32'h0000_3000);
    check("rstw_stall", {31'd0, stall_id}, 32'd0);
    check("rstw_taken", taken_cnt, 32'd0);
    check("rstw_ntaken", ntaken_cnt, 32'd0);
    check("rstw_to", {31'd0, wait_timeout}, 32'd0);
    m_reset();
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 32'd0, 16'd0, 26'd0, 32'd0, 0, 1, 0);
    reset = 1'b0;
    step();
    check("rstw_redir", {31'd0, redirect}, 32'd0);
    check("rstw_pc2", pc_if, 32'h0000_3004);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
